// File: rtl/popcount_seq_ctrl.sv
// Sequential popcount of a WORDS x 16-bit word: one shared 16-bit counter
// walks the slices LSB-first and sums them into an accumulator.
module popcount_seq_ctrl #(
  parameter int unsigned WORDS = 4,
  parameter int unsigned ACC_W = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_count,
  output logic                  busy
);

  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [16*WORDS-1:0] data_q;
  logic [IDX_W-1:0]    idx;
  logic [ACC_W-1:0]    acc;
  logic [15:0]         slice;
  logic [4:0]          slice_cnt;

  // Four 4-bit group counts, two pairwise adder stages, 5-bit total.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [2:0] g [4];
    logic [3:0] s0, s1;
    for (int unsigned i = 0; i < 4; i++) begin
      g[i] = {2'b00, v[4*i]} + {2'b00, v[4*i+1]} +
             {2'b00, v[4*i+2]} + {2'b00, v[4*i+3]};
    end
    s0 = {1'b0, g[0]} + {1'b0, g[1]};
    s1 = {1'b0, g[2]} + {1'b0, g[3]};
    return {1'b0, s0} + {1'b0, s1};
  endfunction

  always_comb begin
    slice = '0;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (idx == IDX_W'(k)) slice = data_q[16*k +: 16];
    end
    slice_cnt = popcount16(slice);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      data_q <= '0;
      idx    <= '0;
      acc    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            idx    <= '0;
            acc    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= acc + ACC_W'(slice_cnt);
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(WORDS - 1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // acc is only written in IDLE (on accept) and RUN, so it is stable in DONE.
  assign out_count = acc;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: doc/popcount_seq_ctrl.md
# popcount_seq_ctrl

Sequencing controller that computes the population count of a wide input word by time-multiplexing one internal 16-bit popcount datapath over `WORDS` consecutive 16-bit slices. Each slice is counted as four 4-bit group counts, two adder stages and a 5-bit result, and the per-slice results are summed in an accumulator. The block accepts one word per valid/ready transaction and returns the total count through a valid/ready output. It sits between a producer that issues wide vectors and any consumer needing their set-bit count, trading latency for a single shared counter.

## Interface
- `WORDS`, 4, number of 16-bit slices per input word (≥1).
- `ACC_W`, 7, accumulator/result width; must satisfy 2^ACC_W > 16*WORDS.

Reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  16*WORDS  word to count; slice k is `in_data[16k+15:16k]`.
- `out_valid`  out  1  `out_count` holds a finished result.
- `out_ready`  in  1  consumer accepts the result.
- `out_count`  out  ACC_W  total number of 1 bits in the accepted word.
- `busy`  out  1  high in RUN or DONE.

## Operation
- Internal storage: `data_q` (16*WORDS), `idx` (slice index), `acc` (ACC_W), and a state register.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: capture `in_data` into `data_q`, clear `acc` and `idx`, and go to RUN.
  - `in_data` is sampled only on the accept edge.
- RUN:
  - `in_ready`=0.
  - Each cycle: `acc <= acc + popcount16(data_q slice idx)`, zero-extended to ACC_W, and `idx` increments.
  - Slices are processed from LSB to MSB: slice 0 first.
  - When `idx == WORDS-1` is processed, go to DONE.
  - For `WORDS`=1, RUN lasts exactly one cycle.
- DONE:
  - `out_valid`=1, and `out_count`=`acc` is held stable.
  - On `out_ready`=1, go to IDLE.
  - `in_ready` stays 0; a word cannot be accepted in the same cycle as the output handshake.
- `popcount16` result range is 0–16 (5 bits).
- The accumulator never overflows under the ACC_W rule, so no saturation or wrap logic is needed.
- `in_valid` outside IDLE is ignored, and no data is captured.
- `out_ready` outside DONE is ignored.
- Output reflects only the accepted word. Later changes to `in_data` have no effect.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_count`=0, `busy`=0.
- Internal `acc`, `idx` and `data_q` all reset to 0.
- Input handshake completes at edge E0. RUN occupies the edges E1..E_WORDS.
- `out_valid` rises in the cycle following edge E_WORDS, i.e. WORDS+1 edges after acceptance (5 with default).
- Output handshake at edge F moves the block to IDLE. `in_ready`=1 in the cycle after F.
- Minimum period between accepted words is WORDS+2 cycles (6 with default).
- Backpressure: while `out_ready`=0 in DONE, `out_valid` and `out_count` hold indefinitely.
- Reset mid-operation: `rst` has priority over every transition.
  - At the reset edge, the block returns to IDLE with all outputs at reset values.
  - The in-flight word and result are discarded; no `out_valid` is produced for them.
- `out_count` is registered (no combinational path from inputs). `in_ready` and `out_valid` are decoded from state only.

## Test plan
- **All-zero word:** accept `in_data`=64'h0 → `out_valid` 5 edges later with `out_count`=0; `in_ready` low from accept until the cycle after the output handshake.
- **All-ones word:** accept `in_data`=64'hFFFF_FFFF_FFFF_FFFF → `out_count`=64 (7'd64), which confirms there is no accumulator overflow.
- **Per-slice ordering:** accept `in_data`=64'h000F_0007_0003_0001 → `out_count`=10. Probe `acc` after each RUN edge and check it reads 1, 3, 6, 10.
- **Backpressure and busy input:**
  - Hold `out_ready`=0 for 6 cycles in DONE and drive a second `in_valid` word throughout → result held stable, second word not accepted.
  - After `out_ready`=1 → second word accepted the cycle after IDLE is re-entered and produces its own correct count.
- **Reset mid-RUN:** assert `rst` at edge E2 of a 64'hFFFF… word → next cycle shows IDLE, `in_ready`=1, `out_valid`=0, `out_count`=0. Then accepting 64'h1 gives `out_count`=1.
- **WORDS=1, ACC_W=5 instance:** `in_data`=16'hFFFF → `out_count`=16, `out_valid` 2 edges after acceptance. Then 16'hA5A5 → 8.
